// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: synchronous BCD decade up/down counter with
// synchronous clear, parallel load, P/T count enables and ripple carry.
//
// Ports:
//   clk     rising-edge clock for all state changes
//   clr     synchronous clear, active low (highest priority)
//   load_n  synchronous parallel load, active low
//   enp_n   count enable P, active low
//   ent_n   count enable T (cascade input), active low, also gates rco_n
//   u_d     direction, 1 = up, 0 = down
//   d[3:0]  parallel load data
//   q[3:0]  counter state
//   rco_n   ripple carry/borrow, active low, combinational
//   dec_n   1-of-10 active-low decode of q (only with SN74LS_DEC_OUT_EN)
//
// Build option: define SN74LS_DEC_OUT_EN to add the dec_n output.
// Board-level propagation delays are not part of this synthesizable model.

module bcd_updown_counter (
    input  logic       clk,
    input  logic       clr,
    input  logic       load_n,
    input  logic       enp_n,
    input  logic       ent_n,
    input  logic       u_d,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       rco_n
`ifdef SN74LS_DEC_OUT_EN
    ,
    output logic [9:0] dec_n
`endif
);

    logic       is_bcd;
    logic       at_max;
    logic       at_min;
    logic       cnt_en;
    logic [3:0] up_next;
    logic [3:0] dn_next;
    logic [3:0] cnt_next;
    logic [3:0] q_next;

    // Codes 10..15 have q[3] set together with q[2] or q[1].
    assign is_bcd = ~(q[3] & (q[2] | q[1]));
    assign at_max = (q == 4'd9);
    assign at_min = (q == 4'd0);

    // Illegal codes recover in a single counting edge:
    // to 0 when counting up, to 9 when counting down.
    always_comb begin
        up_next = 4'd0;
        if (is_bcd && !at_max) begin
            up_next = q + 4'd1;
        end
    end

    always_comb begin
        dn_next = 4'd9;
        if (is_bcd && !at_min) begin
            dn_next = q - 4'd1;
        end
    end

    assign cnt_next = u_d ? up_next : dn_next;
    assign cnt_en   = ~enp_n & ~ent_n;

    // Conditional operators rather than if/else so that an unknown
    // control input yields an unknown next state instead of silently
    // choosing one branch.
    assign q_next = ~clr    ? 4'd0     :
                    ~load_n ? d        :
                    cnt_en  ? cnt_next :
                              q;

    always_ff @(posedge clk) begin
        q <= q_next;
    end

    // Terminal count depends on direction; illegal codes never match.
    assign rco_n = ~(~ent_n & (u_d ? at_max : at_min));

`ifdef SN74LS_DEC_OUT_EN
    always_comb begin
        dec_n = '1;
        for (int i = 0; i < 10; i++) begin
            if (q == 4'(i)) begin
                dec_n[i] = 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: driver pushes expected
// results from an arithmetic model, a monitor pops and compares.

module tb_bcd_updown_counter;

    logic       clk = 1'b0;
    logic       clr;
    logic       load_n;
    logic       enp_n;
    logic       ent_n;
    logic       u_d;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco_n;

    logic       c_clr;
    logic [3:0] lo_q;
    logic       lo_rco;
    logic [3:0] hi_q;
    logic       hi_rco;

`ifdef SN74LS_DEC_OUT_EN
    logic [9:0] dec_n;
    logic [9:0] lo_dec;
    logic [9:0] hi_dec;
`endif

    always #5 clk = ~clk;

    bcd_updown_counter dut (
        .clk    (clk),
        .clr    (clr),
        .load_n (load_n),
        .enp_n  (enp_n),
        .ent_n  (ent_n),
        .u_d    (u_d),
        .d      (d),
        .q      (q),
        .rco_n  (rco_n)
`ifdef SN74LS_DEC_OUT_EN
        ,
        .dec_n  (dec_n)
`endif
    );

    bcd_updown_counter lo (
        .clk    (clk),
        .clr    (c_clr),
        .load_n (1'b1),
        .enp_n  (1'b0),
        .ent_n  (1'b0),
        .u_d    (1'b1),
        .d      (4'd0),
        .q      (lo_q),
        .rco_n  (lo_rco)
`ifdef SN74LS_DEC_OUT_EN
        ,
        .dec_n  (lo_dec)
`endif
    );

    bcd_updown_counter hi (
        .clk    (clk),
        .clr    (c_clr),
        .load_n (1'b1),
        .enp_n  (1'b0),
        .ent_n  (lo_rco),
        .u_d    (1'b1),
        .d      (4'd0),
        .q      (hi_q),
        .rco_n  (hi_rco)
`ifdef SN74LS_DEC_OUT_EN
        ,
        .dec_n  (hi_dec)
`endif
    );

    typedef struct {
        int   q;
        logic rco;
        int   cval;
        logic crco;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    int mq = 0;
    int cval = 0;
    bit cas_started = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // One clock of stimulus: drive at negedge, model the next rising edge.
    task automatic step(input logic c, input logic l, input logic p,
                        input logic t, input logic u, input logic [3:0] dv);
        exp_t e;
        @(negedge clk);
        clr    = c;
        load_n = l;
        enp_n  = p;
        ent_n  = t;
        u_d    = u;
        d      = dv;
        c_clr  = cas_started;
        if (!c) begin
            mq = 0;
        end else if (!l) begin
            mq = int'(dv);
        end else if (!p && !t) begin
            if (u) mq = (mq > 9) ? 0 : (mq + 1) % 10;
            else   mq = (mq > 9 || mq == 0) ? 9 : mq - 1;
        end
        cval = cas_started ? (cval + 1) % 100 : 0;
        cas_started = 1;
        e.q    = mq;
        e.rco  = !(!t && ((u && mq == 9) || (!u && mq == 0)));
        e.cval = cval;
        e.crco = (cval != 99);
        sb.push_back(e);
    endtask

    // Monitor: every rising edge the DUT presents a new state.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (q !== 4'(e.q)) begin
                    errors++;
                    $display("FAIL q got %0d want %0d", q, e.q);
                end
                checks++;
                if (rco_n !== e.rco) begin
                    errors++;
                    $display("FAIL rco_n q=%0d got %0b want %0b",
                             q, rco_n, e.rco);
                end
                chk("cascade", int'(hi_q) * 10 + int'(lo_q), e.cval);
                checks++;
                if (hi_rco !== e.crco) begin
                    errors++;
                    $display("FAIL cascade_rco got %0b want %0b",
                             hi_rco, e.crco);
                end
`ifdef SN74LS_DEC_OUT_EN
                begin
                    logic [9:0] wd;
                    wd = '1;
                    if (e.q < 10) wd[e.q] = 1'b0;
                    checks++;
                    if (dec_n !== wd) begin
                        errors++;
                        $display("FAIL dec_n q=%0d got %b want %b",
                                 e.q, dec_n, wd);
                    end
                end
`endif
            end
        end
    end

    initial begin
        clr = 1'b0; load_n = 1'b0; enp_n = 1'b0;
        ent_n = 1'b0; u_d = 1'b0; d = 4'd7; c_clr = 1'b0;

        // reset wins over load; rco_n follows u_d at q=0
        step(0, 0, 0, 0, 0, 4'd7);
        step(0, 0, 0, 0, 1, 4'd7);

        // up count across the 9 -> 0 wrap
        repeat (12) step(1, 1, 0, 0, 1, 4'd0);

        // down count from 3 across the 0 -> 9 wrap
        step(1, 0, 0, 0, 0, 4'd3);
        repeat (5) step(1, 1, 0, 0, 0, 4'd0);

        // enable P holds, enable T holds and kills rco_n
        repeat (3) step(1, 1, 1, 0, 0, 4'd0);
        step(1, 0, 0, 0, 0, 4'd0);
        repeat (3) step(1, 1, 0, 1, 0, 4'd0);
        step(1, 0, 0, 0, 1, 4'd9);
        repeat (2) step(1, 1, 0, 1, 1, 4'd0);

        // illegal code recovery
        step(1, 0, 1, 1, 1, 4'd12);
        step(1, 1, 0, 0, 1, 4'd0);
        step(1, 0, 1, 1, 0, 4'd15);
        step(1, 1, 0, 0, 0, 4'd0);

        // clear mid-count, then resume from 0
        step(1, 1, 0, 0, 1, 4'd0);
        step(0, 1, 0, 0, 1, 4'd0);
        step(1, 1, 0, 0, 1, 4'd0);

        // load sweep over every code
        for (int v = 0; v < 16; v++) begin
            step(1, 0, 0, 0, v[0], 4'(v));
        end

        // randomized traffic, biased towards counting
        for (int k = 0; k < 300; k++) begin
            logic c, l, p, t, u;
            c = ($urandom_range(0, 31) != 0);
            l = ($urandom_range(0, 9) != 0);
            p = ($urandom_range(0, 5) == 0);
            t = ($urandom_range(0, 5) == 0);
            u = 1'($urandom_range(0, 1));
            step(c, l, p, t, u, 4'($urandom_range(0, 15)));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
